led_sequencer: RTL

- Parametrised successor to the fixed 4-LED board chaser: drives N_LED outputs with a runtime-selectable pattern mode (rotate left, rotate right, bounce, blink-all).
- Adds a programmable step period, a run/freeze enable, a synchronous clear, and a global PWM brightness control.
- Sits directly between the board clock/reset and the LED pins; step_tick is available for other status logic.

---
 rtl/led_sequencer.sv | 114 +++++++++++
 1 files changed

// File: rtl/led_sequencer.sv
// Pattern sequencer for N_LED outputs: rotate / bounce / blink-all stepped
// every STEP_CYCLES clocks, with a global PWM brightness gate on the outputs.
module led_sequencer #(
  parameter  int N_LED       = 4,
  parameter  int STEP_CYCLES = 25_000_000,
  parameter  int PWM_BITS    = 4,
  localparam int POS_W       = (N_LED > 1) ? $clog2(N_LED) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                en,
  input  logic [1:0]          mode,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [N_LED-1:0]    led,
  output logic                step_tick,
  output logic [POS_W-1:0]    pos
);

  typedef enum logic [1:0] {M_ROL = 2'b00, M_ROR = 2'b01, M_BOUNCE = 2'b10, M_BLINK = 2'b11} mode_t;
  typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;

  localparam logic [31:0]      STEP_LAST = 32'(STEP_CYCLES - 1);
  localparam logic [POS_W-1:0] POS_LAST  = POS_W'(N_LED - 1);
  localparam logic [POS_W-1:0] POS_ONE   = POS_W'(1);

  logic [31:0]         timer, timer_nxt;
  logic [PWM_BITS-1:0] pwm_cnt;
  dir_t                dir, dir_nxt;
  logic                phase, phase_nxt;
  mode_t               mode_r, mode_nxt;
  logic [POS_W-1:0]    pos_nxt;
  logic                tick, tick_nxt;
  logic                pwm_on;
  logic [N_LED-1:0]    pattern;

  assign tick = en && !clear && (timer == STEP_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer     <= '0;
      pwm_cnt   <= '0;
      dir       <= UP;
      phase     <= 1'b0;
      mode_r    <= M_ROL;
      pos       <= '0;
      step_tick <= 1'b0;
      led       <= '0;
    end else begin
      timer     <= timer_nxt;
      pwm_cnt   <= pwm_cnt + 1'b1;
      dir       <= dir_nxt;
      phase     <= phase_nxt;
      mode_r    <= mode_nxt;
      pos       <= pos_nxt;
      step_tick <= tick_nxt;
      led       <= pattern & {N_LED{pwm_on}};
    end
  end

  // Step state only moves on a tick; clear overrides both running and ticking.
  always_comb begin
    timer_nxt = timer;
    dir_nxt   = dir;
    phase_nxt = phase;
    mode_nxt  = mode_r;
    pos_nxt   = pos;
    tick_nxt  = 1'b0;
    if (clear) begin
      timer_nxt = '0;
      pos_nxt   = '0;
      dir_nxt   = UP;
      phase_nxt = 1'b0;
      mode_nxt  = mode_t'(mode);
    end else if (tick) begin
      timer_nxt = '0;
      mode_nxt  = mode_t'(mode);
      tick_nxt  = 1'b1;
      phase_nxt = 1'b0;
      case (mode_t'(mode))
        M_ROL: pos_nxt = (pos == POS_LAST) ? '0 : pos + POS_ONE;
        M_ROR: pos_nxt = (pos == '0) ? POS_LAST : pos - POS_ONE;
        M_BOUNCE: begin
          if (dir == UP) begin
            if (pos == POS_LAST) begin
              dir_nxt = DOWN;
              pos_nxt = POS_LAST - POS_ONE;
            end else begin
              pos_nxt = pos + POS_ONE;
            end
          end else begin
            if (pos == '0) begin
              dir_nxt = UP;
              pos_nxt = POS_ONE;
            end else begin
              pos_nxt = pos - POS_ONE;
            end
          end
        end
        M_BLINK: phase_nxt = (mode_r != M_BLINK) ? 1'b1 : ~phase;
        default: pos_nxt = pos;
      endcase
    end else if (en) begin
      timer_nxt = timer + 32'd1;
    end
  end

  assign pwm_on = (&brightness) || (pwm_cnt < brightness);

  for (genvar i = 0; i < N_LED; i++) begin : g_lane
    assign pattern[i] = (mode_r == M_BLINK) ? phase : (pos == POS_W'(i));
  end

endmodule
